crank_wheel_sim: RTL and testbench

CRANK_WHEEL_SIM -- requirements
Module: crank_wheel_sim

---
 rtl/crank_wheel_sim.sv | 215 +++++++++++++++++++++
 tb/tb_crank_wheel_sim.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crank_wheel_sim.sv
`default_nettype none
// ============================================================================
// Module      : crank_wheel_sim
// Description : Synthetic crank-wheel (N-M missing tooth) trigger generator.
//               Each tooth slot is 2*active clk cycles long: active cycles high
//               (HI) then active cycles low (LO). The last N_MISSING slots of
//               every revolution stay low, which forms the sync gap. A cam
//               output marks one slot in every second revolution, so a
//               decoder can tell the two halves of the 720-degree cycle apart.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   single clock
//   reset       in   asynchronous active-low reset
//   enable      in   run request; a running slot always completes
//   half_period in   requested clk cycles per tooth half (PER_W bits)
//   load        in   single-cycle strobe that captures half_period
//   vrin        out  synthetic crank trigger waveform
//   tooth       out  current slot index 0..N_TEETH-1
//   rev_pulse   out  one-cycle pulse on the first HI cycle of slot 0
//   phase       out  which revolution of the 720-degree cycle is running
//   cam         out  high for the whole CAM_TOOTH slot while phase=1
//   err         out  sticky flag, set by a load with half_period < 2
// ============================================================================
module crank_wheel_sim #(
  parameter int N_TEETH   = 60,
  parameter int N_MISSING = 2,
  parameter int PER_W     = 20,
  parameter int DEF_HALF  = 400,
  parameter int CAM_TOOTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [PER_W-1:0]           half_period,
  input  logic                       load,
  output logic                       vrin,
  output logic [$clog2(N_TEETH)-1:0] tooth,
  output logic                       rev_pulse,
  output logic                       phase,
  output logic                       cam,
  output logic                       err
);

  localparam int TW = $clog2(N_TEETH);

  localparam logic [TW-1:0]    C_LAST_TOOTH = TW'(N_TEETH - 1);
  localparam logic [TW-1:0]    C_FIRST_GAP  = TW'(N_TEETH - N_MISSING);
  localparam logic [TW-1:0]    C_CAM_TOOTH  = TW'(CAM_TOOTH);
  localparam logic [PER_W-1:0] C_DEF_HALF   = PER_W'(DEF_HALF);
  localparam logic [PER_W-1:0] C_MIN_HALF   = PER_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic [PER_W-1:0]   r_cnt;
  logic [TW-1:0]      r_tooth;
  logic               r_phase;
  logic [PER_W-1:0]   r_active;
  logic [PER_W-1:0]   r_pending;
  logic               r_err;
  logic               r_vrin;
  logic               r_rev;
  logic               r_cam;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [PER_W-1:0]   w_cnt_nxt;
  logic [TW-1:0]      w_tooth_nxt;
  logic               w_phase_nxt;
  logic [PER_W-1:0]   w_active_nxt;
  logic               w_half_end;
  logic               w_vrin_nxt;
  logic               w_rev_nxt;
  logic               w_cam_nxt;
  logic               w_load_ok;
  logic               w_load_bad;

  // Last cycle of the current half (HI or LO).
  assign w_half_end = (r_cnt == (r_active - 1'b1));

  // A load is only accepted when the half-period can produce a real edge.
  assign w_load_ok  = load && (half_period >= C_MIN_HALF);
  assign w_load_bad = load && (half_period <  C_MIN_HALF);

  // --------------------------------------------------------------------------
  // Slot sequencer: next state, counter, tooth index, phase, active period.
  // active only changes when a new slot begins, so each slot is built from a
  // single half-period value.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_tooth_nxt  = r_tooth;
    w_phase_nxt  = r_phase;
    w_active_nxt = r_active;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (enable) begin
          w_state_nxt  = ST_HI;
          w_active_nxt = r_pending;
        end
      end

      ST_HI: begin
        if (w_half_end) begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end

      ST_LO: begin
        if (w_half_end) begin
          // Slot boundary: the tooth always advances, even when stopping,
          // so a later re-enable resumes on the following slot.
          w_cnt_nxt    = '0;
          w_active_nxt = r_pending;
          w_state_nxt  = enable ? ST_HI : ST_IDLE;
          if (r_tooth == C_LAST_TOOTH) begin
            w_tooth_nxt = '0;
            w_phase_nxt = ~r_phase;
          end else begin
            w_tooth_nxt = r_tooth + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from next-state values, so the registered outputs line up
  // with the state they describe and no input reaches an output directly.
  // --------------------------------------------------------------------------
  always_comb begin
    w_vrin_nxt = (w_state_nxt == ST_HI) && (w_tooth_nxt < C_FIRST_GAP);
    // Entering HI from LO or IDLE on slot 0 is the first HI cycle of slot 0.
    w_rev_nxt  = (w_state_nxt == ST_HI) && (r_state != ST_HI) &&
                 (w_tooth_nxt == '0);
    w_cam_nxt  = (w_state_nxt != ST_IDLE) && (w_tooth_nxt == C_CAM_TOOTH) &&
                 w_phase_nxt;
  end

  // --------------------------------------------------------------------------
  // Sequencer and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tooth  <= '0;
      r_phase  <= 1'b0;
      r_active <= C_DEF_HALF;
      r_vrin   <= 1'b0;
      r_rev    <= 1'b0;
      r_cam    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tooth  <= w_tooth_nxt;
      r_phase  <= w_phase_nxt;
      r_active <= w_active_nxt;
      r_vrin   <= w_vrin_nxt;
      r_rev    <= w_rev_nxt;
      r_cam    <= w_cam_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Period request register and sticky error flag. When a load lands on a
  // slot boundary, active takes the old pending value on that same edge and
  // the new value waits for the next boundary.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= C_DEF_HALF;
      r_err     <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_pending <= half_period;
      end
      if (w_load_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign vrin      = r_vrin;
  assign tooth     = r_tooth;
  assign rev_pulse = r_rev;
  assign phase     = r_phase;
  assign cam       = r_cam;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_crank_wheel_sim.sv
`default_nettype none
// ============================================================================
// Module      : tb_crank_wheel_sim
// Description : Self-checking bench for crank_wheel_sim (12-1 wheel, half
//               period 4, cam on slot 2). A slot-level reference model tracks
//               the position inside the current slot and derives every
//               expected output from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crank_wheel_sim;

  localparam int NT = 12;
  localparam int NM = 1;
  localparam int PW = 8;
  localparam int DH = 4;
  localparam int CT = 2;
  localparam int TW = 4;

  logic          clk         = 1'b0;
  logic          reset       = 1'b1;
  logic          enable      = 1'b0;
  logic          load        = 1'b0;
  logic [PW-1:0] half_period = '0;
  logic          vrin;
  logic [TW-1:0] tooth;
  logic          rev_pulse;
  logic          phase;
  logic          cam;
  logic          err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: running flag, position within the slot (0..2p-1),
  // slot period, pending period, tooth index, phase and error flag.
  bit m_run;
  int m_pos;
  int m_p;
  int m_pend;
  int m_tooth;
  bit m_phase;
  bit m_err;

  crank_wheel_sim #(
    .N_TEETH  (NT),
    .N_MISSING(NM),
    .PER_W    (PW),
    .DEF_HALF (DH),
    .CAM_TOOTH(CT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .half_period(half_period),
    .load       (load),
    .vrin       (vrin),
    .tooth      (tooth),
    .rev_pulse  (rev_pulse),
    .phase      (phase),
    .cam        (cam),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_run = 0; m_pos = 0; m_p = DH; m_pend = DH;
    m_tooth = 0; m_phase = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit en, input bit ld, input int hp);
    if (!m_run) begin
      if (en) begin
        m_run = 1; m_pos = 0; m_p = m_pend;
      end
    end else if (m_pos == 2 * m_p - 1) begin
      m_pos = 0;
      m_p   = m_pend;
      m_run = en;
      if (m_tooth == NT - 1) begin
        m_tooth = 0; m_phase = !m_phase;
      end else begin
        m_tooth = m_tooth + 1;
      end
    end else begin
      m_pos = m_pos + 1;
    end
    if (ld) begin
      if (hp >= 2) m_pend = hp;
      else         m_err  = 1;
    end
  endfunction

  function automatic bit exp_vrin();
    return m_run && (m_pos < m_p) && (m_tooth < NT - NM);
  endfunction

  function automatic bit exp_rev();
    return m_run && (m_pos == 0) && (m_tooth == 0);
  endfunction

  function automatic bit exp_cam();
    return m_run && (m_tooth == CT) && m_phase;
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle 1 time unit.
  task automatic tick(input bit en, input bit ld, input int hp);
    enable      = en;
    load        = ld;
    half_period = PW'(hp);
    @(posedge clk);
    model_step(en, ld, hp);
    #1;
    load = 1'b0;
  endtask

  task automatic apply_reset();
    enable = 1'b0;
    load   = 1'b0;
    reset  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    n_cmp++; if (vrin !== 1'b0)      begin n_fail++; $display("FAIL reset_vrin got=%b exp=0", vrin); end
    n_cmp++; if (tooth !== '0)       begin n_fail++; $display("FAIL reset_tooth got=%0d exp=0", tooth); end
    n_cmp++; if (rev_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_rev got=%b exp=0", rev_pulse); end
    n_cmp++; if (phase !== 1'b0)     begin n_fail++; $display("FAIL reset_phase got=%b exp=0", phase); end
    n_cmp++; if (cam !== 1'b0)       begin n_fail++; $display("FAIL reset_cam got=%b exp=0", cam); end
    n_cmp++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    repeat (3) tick(0, 0, 0);
    n_cmp++; if (vrin !== 1'b0)      begin n_fail++; $display("FAIL idle_vrin got=%b exp=0", vrin); end
    n_cmp++; if (tooth !== '0)       begin n_fail++; $display("FAIL idle_tooth got=%0d exp=0", tooth); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_golden();
    int rev_cnt = 0;
    int rev_at[2] = '{-1, -1};
    int cam_cnt = 0;
    int hi_cnt  = 0;
    bit first_vrin = 0;
    apply_reset();
    for (int cyc = 0; cyc < 192; cyc++) begin
      tick(1, 0, 0);
      if (cyc == 0) first_vrin = vrin;
      n_cmp++; if (vrin !== exp_vrin()) begin n_fail++; $display("FAIL golden_vrin cyc=%0d got=%b exp=%b", cyc, vrin, exp_vrin()); end
      n_cmp++; if (tooth !== TW'(m_tooth)) begin n_fail++; $display("FAIL golden_tooth cyc=%0d got=%0d exp=%0d", cyc, tooth, m_tooth); end
      n_cmp++; if (rev_pulse !== exp_rev()) begin n_fail++; $display("FAIL golden_rev cyc=%0d got=%b exp=%b", cyc, rev_pulse, exp_rev()); end
      n_cmp++; if (cam !== exp_cam()) begin n_fail++; $display("FAIL golden_cam cyc=%0d got=%b exp=%b", cyc, cam, exp_cam()); end
      if (rev_pulse === 1'b1) begin
        if (rev_cnt < 2) rev_at[rev_cnt] = cyc;
        rev_cnt++;
      end
      if (cam === 1'b1)  cam_cnt++;
      if (vrin === 1'b1) hi_cnt++;
    end
    n_cmp++; if (first_vrin !== 1'b1) begin n_fail++; $display("FAIL golden_first_vrin got=%b exp=1", first_vrin); end
    n_cmp++; if (rev_cnt != 2) begin n_fail++; $display("FAIL golden_rev_count got=%0d exp=2", rev_cnt); end
    n_cmp++; if (rev_at[1] - rev_at[0] != 96) begin n_fail++; $display("FAIL golden_rev_interval got=%0d exp=96", rev_at[1] - rev_at[0]); end
    n_cmp++; if (cam_cnt != 8) begin n_fail++; $display("FAIL golden_cam_count got=%0d exp=8", cam_cnt); end
    n_cmp++; if (hi_cnt != 88) begin n_fail++; $display("FAIL golden_vrin_high got=%0d exp=88", hi_cnt); end
  endtask

  // --------------------------------------------------------------------------
  // Load 6 either mid-slot 3 or on slot 3's boundary cycle; count DUT high and
  // low cycles per tooth and compare with the fixed expected slot shapes.
  task automatic test_load(input bit on_boundary);
    int hi[NT];
    int lo[NT];
    int guard = 0;
    bit loaded = 0;
    int stop_tooth = on_boundary ? 6 : 5;
    int t4 = on_boundary ? 4 : 6;
    int t5 = 6;
    for (int i = 0; i < NT; i++) begin hi[i] = 0; lo[i] = 0; end
    apply_reset();
    while (!(m_run && m_tooth == stop_tooth) && guard < 300) begin
      bit ld = 0;
      if (!loaded && m_run && m_tooth == 3 &&
          (on_boundary ? (m_pos == 2 * m_p - 1) : (m_pos == 2))) begin
        ld = 1; loaded = 1;
      end
      tick(1, ld, 6);
      guard++;
      n_cmp++; if (vrin !== exp_vrin()) begin n_fail++; $display("FAIL load_vrin bnd=%0d cyc=%0d got=%b exp=%b", on_boundary, guard, vrin, exp_vrin()); end
      if (int'(tooth) < NT) begin
        if (vrin === 1'b1) hi[tooth]++;
        else               lo[tooth]++;
      end
    end
    n_cmp++; if (guard >= 300) begin n_fail++; $display("FAIL load_timeout bnd=%0d got=timeout exp=tooth%0d", on_boundary, stop_tooth); end
    n_cmp++; if (hi[3] != 4) begin n_fail++; $display("FAIL load_slot3_hi bnd=%0d got=%0d exp=4", on_boundary, hi[3]); end
    n_cmp++; if (lo[3] != 4) begin n_fail++; $display("FAIL load_slot3_lo bnd=%0d got=%0d exp=4", on_boundary, lo[3]); end
    n_cmp++; if (hi[4] != t4) begin n_fail++; $display("FAIL load_slot4_hi bnd=%0d got=%0d exp=%0d", on_boundary, hi[4], t4); end
    n_cmp++; if (lo[4] != t4) begin n_fail++; $display("FAIL load_slot4_lo bnd=%0d got=%0d exp=%0d", on_boundary, lo[4], t4); end
    if (on_boundary) begin
      n_cmp++; if (hi[5] != t5) begin n_fail++; $display("FAIL load_slot5_hi got=%0d exp=%0d", hi[5], t5); end
      n_cmp++; if (lo[5] != t5) begin n_fail++; $display("FAIL load_slot5_lo got=%0d exp=%0d", lo[5], t5); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_bad_load();
    int hi_cnt = 0;
    apply_reset();
    for (int cyc = 0; cyc < 96; cyc++) begin
      tick(1, cyc == 5, 1);
      if (vrin === 1'b1) hi_cnt++;
      n_cmp++; if (vrin !== exp_vrin()) begin n_fail++; $display("FAIL badload_vrin cyc=%0d got=%b exp=%b", cyc, vrin, exp_vrin()); end
      if (cyc == 4) begin
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL badload_err_before got=%b exp=0", err); end
      end
    end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL badload_err got=%b exp=1", err); end
    n_cmp++; if (hi_cnt != 44) begin n_fail++; $display("FAIL badload_vrin_high got=%0d exp=44", hi_cnt); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stop_resume();
    int guard = 0;
    int h5 = 0;
    apply_reset();
    while (!(m_run && m_tooth == 5 && m_pos == 1) && guard < 100) begin
      tick(1, 0, 0);
      guard++;
      if (vrin === 1'b1 && tooth == 5) h5++;
    end
    n_cmp++; if (guard >= 100) begin n_fail++; $display("FAIL stop_reach_timeout got=timeout exp=slot5"); end
    guard = 0;
    while (m_run && guard < 20) begin
      tick(0, 0, 0);
      guard++;
      if (vrin === 1'b1 && tooth == 5) h5++;
      n_cmp++; if (vrin !== exp_vrin()) begin n_fail++; $display("FAIL stop_vrin cyc=%0d got=%b exp=%b", guard, vrin, exp_vrin()); end
    end
    n_cmp++; if (guard >= 20) begin n_fail++; $display("FAIL stop_idle_timeout got=timeout exp=idle"); end
    n_cmp++; if (h5 != 4) begin n_fail++; $display("FAIL stop_slot5_high got=%0d exp=4", h5); end
    n_cmp++; if (tooth !== TW'(6)) begin n_fail++; $display("FAIL stop_tooth got=%0d exp=6", tooth); end
    repeat (5) tick(0, 0, 0);
    n_cmp++; if (tooth !== TW'(6)) begin n_fail++; $display("FAIL stop_hold_tooth got=%0d exp=6", tooth); end
    n_cmp++; if (vrin !== 1'b0) begin n_fail++; $display("FAIL stop_hold_vrin got=%b exp=0", vrin); end
    tick(1, 0, 0);
    n_cmp++; if (tooth !== TW'(6)) begin n_fail++; $display("FAIL resume_tooth got=%0d exp=6", tooth); end
    n_cmp++; if (vrin !== 1'b1) begin n_fail++; $display("FAIL resume_vrin got=%b exp=1", vrin); end
    n_cmp++; if (rev_pulse !== 1'b0) begin n_fail++; $display("FAIL resume_rev got=%b exp=0", rev_pulse); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    int guard = 0;
    apply_reset();
    tick(1, 1, 1);
    while (!(m_tooth == 4 && m_pos == 1) && guard < 100) begin
      tick(1, 0, 0);
      guard++;
    end
    n_cmp++; if (guard >= 100) begin n_fail++; $display("FAIL rstmid_reach_timeout got=timeout exp=slot4"); end
    n_cmp++; if (vrin !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_vrin got=%b exp=1", vrin); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_err got=%b exp=1", err); end
    // Assert reset between clock edges; outputs must clear with no edge.
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (vrin !== 1'b0) begin n_fail++; $display("FAIL rstmid_vrin got=%b exp=0", vrin); end
    n_cmp++; if (tooth !== '0) begin n_fail++; $display("FAIL rstmid_tooth got=%0d exp=0", tooth); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got=%b exp=0", err); end
    model_reset();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1, 0, 0);
    n_cmp++; if (vrin !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart_vrin got=%b exp=1", vrin); end
    n_cmp++; if (rev_pulse !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart_rev got=%b exp=1", rev_pulse); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit en = ($urandom_range(0, 99) < 85);
      bit ld = ($urandom_range(0, 99) < 3);
      int hp = int'($urandom_range(0, 7));
      tick(en, ld, hp);
      n_cmp++; if (vrin !== exp_vrin()) begin n_fail++; $display("FAIL rand_vrin cyc=%0d got=%b exp=%b", cyc, vrin, exp_vrin()); end
      n_cmp++; if (tooth !== TW'(m_tooth)) begin n_fail++; $display("FAIL rand_tooth cyc=%0d got=%0d exp=%0d", cyc, tooth, m_tooth); end
      n_cmp++; if (phase !== m_phase) begin n_fail++; $display("FAIL rand_phase cyc=%0d got=%b exp=%b", cyc, phase, m_phase); end
      n_cmp++; if (rev_pulse !== exp_rev()) begin n_fail++; $display("FAIL rand_rev cyc=%0d got=%b exp=%b", cyc, rev_pulse, exp_rev()); end
      n_cmp++; if (cam !== exp_cam()) begin n_fail++; $display("FAIL rand_cam cyc=%0d got=%b exp=%b", cyc, cam, exp_cam()); end
      n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, err, m_err); end
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_golden();
    test_load(1'b0);
    test_load(1'b1);
    test_bad_load();
    test_stop_resume();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
